// File: rtl/tty_pkg.sv
// Shared teleprinter definitions: shifter states, IOT function bits, device
// codes and the baud-counter width helper used by transmit and receive logic.
package tty_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tty_tx_state_t;

    localparam int unsigned IOT_SKIP = 32'd0;
    localparam int unsigned IOT_CLRF = 32'd1;
    localparam int unsigned IOT_LOAD = 32'd2;

    localparam logic [5:0] TTY_KBD = 6'o03;
    localparam logic [5:0] TTY_PRN = 6'o04;

    // Width of a counter that must hold 0..clks-1; never narrower than one bit.
    function automatic int cnt_width(input int clks);
        return (clks <= 32'sd2) ? 32'sd1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/tty_bit_timer.sv
// Baud counter shared by the teleprinter shifters: counts 0..CLKS_PER_BIT-1,
// wraps, and flags the final cycle of each bit period.
module tty_bit_timer
    import tty_pkg::*;
#(
    parameter int CLKS_PER_BIT = 32'sd434
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic restart_i,
    output logic bit_end_o
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 32'sd1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: restart pins the counter at zero, otherwise wrap at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = CW'(0);
        end else if (cnt_q == LAST) begin
            cnt_d = CW'(0);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= CW'(0);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = (cnt_q == LAST);

endmodule

// File: rtl/tty_printer_tx.sv
// Teleprinter output device (IOT 604x): one-character buffer, async serial
// shifter onto TXD, and the printer flag feeding skip and interrupt request.
module tty_printer_tx
    import tty_pkg::*;
#(
    parameter int CLKS_PER_BIT = 32'sd434,
    parameter int STOP_BITS    = 32'sd2,
    parameter bit FORCE_B7     = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       EN,
    input  logic [2:0] IR,
    input  logic [7:0] AC,
    input  logic       ck1,
    input  logic       ck2,
    input  logic       ck3,
    input  logic       stb1,
    input  logic       stb2,
    output logic       done,
    output logic       pc_ck,
    output logic       irq,
    output logic       flag,
    output logic       busy,
    output logic       TXD
);

    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 32'sd1);

    tty_tx_state_t state_q, state_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    buf_q, buf_d;
    logic          buf_full_q, buf_full_d;
    logic          flag_q, flag_d;
    logic          busy_q, busy_d;
    logic          txd_q, txd_d;

    logic iot1_s, iot2_s, load_s, clr_s;
    logic bit_end_s, restart_s, frame_end_s;

    assign iot1_s = EN & ck1 & stb1;
    assign iot2_s = EN & ck2 & stb2;
    assign load_s = iot2_s & IR[IOT_LOAD];
    assign clr_s  = iot2_s & IR[IOT_CLRF];

    // Skip is judged on the flag before any clear in the same instruction.
    assign pc_ck = iot1_s & IR[IOT_SKIP] & flag_q;
    assign done  = EN & ck3;
    assign flag  = flag_q;
    assign irq   = flag_q;
    assign busy  = busy_q;
    assign TXD   = txd_q;

    tty_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i     (CLK),
        .rst_n_i   (RESET_N),
        .restart_i (restart_s),
        .bit_end_o (bit_end_s)
    );

    // Shifter sequencing, buffer hand-off and flag update.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        flag_d      = flag_q;
        frame_end_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (buf_full_q) begin
                    shreg_d    = {buf_q[7] | FORCE_B7, buf_q[6:0]};
                    buf_full_d = 1'b0;
                    state_d    = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_d = DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d   = STOP;
                        bit_idx_d = 3'd0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = {1'b0, shreg_q[7:1]};
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    if (bit_idx_q == STOP_LAST) begin
                        state_d     = IDLE;
                        bit_idx_d   = 3'd0;
                        frame_end_s = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_idx_d = 3'd0;
            end
        endcase

        // A fresh load always wins over the hand-off: the new character waits.
        if (load_s) begin
            buf_d      = AC;
            buf_full_d = 1'b1;
        end else begin
            buf_d = buf_d;
        end

        if (frame_end_s) begin
            flag_d = 1'b1;
        end else if (clr_s) begin
            flag_d = 1'b0;
        end else begin
            flag_d = flag_q;
        end
    end

    assign restart_s = (state_q == IDLE) | (state_d != state_q);

    // Output values are decoded from next state so TXD and busy come straight off flops.
    always_comb begin
        busy_d = (state_d != IDLE) | buf_full_d;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    // Device registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            bit_idx_q  <= 3'd0;
            shreg_q    <= 8'h00;
            buf_q      <= 8'h00;
            buf_full_q <= 1'b0;
            flag_q     <= 1'b0;
            busy_q     <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            flag_q     <= flag_d;
            busy_q     <= busy_d;
            txd_q      <= txd_d;
        end
    end

endmodule

// File: tb/tb_tty_printer_tx.sv
// Directed bench for tty_printer_tx: two instances (FORCE_B7 off/on) share
// stimulus and are checked every cycle against a frame-timeline model.
module tb_tty_printer_tx;

    localparam int C  = 4;
    localparam int S  = 2;
    localparam int FL = (9 + S) * C;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       EN = 1'b0;
    logic [2:0] IR = 3'b000;
    logic [7:0] AC = 8'h00;
    logic       ck1 = 1'b0, ck2 = 1'b0, ck3 = 1'b0, stb1 = 1'b0, stb2 = 1'b0;

    logic done0, pc0, irq0, flag0, busy0, txd0;
    logic done1, pc1, irq1, flag1, busy1, txd1;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    logic pc_a, done_c;

    always #5 CLK = ~CLK;

    tty_printer_tx #(.CLKS_PER_BIT(C), .STOP_BITS(S), .FORCE_B7(1'b0)) u_dut0 (
        .CLK(CLK), .RESET_N(RESET_N), .EN(EN), .IR(IR), .AC(AC),
        .ck1(ck1), .ck2(ck2), .ck3(ck3), .stb1(stb1), .stb2(stb2),
        .done(done0), .pc_ck(pc0), .irq(irq0), .flag(flag0), .busy(busy0), .TXD(txd0));

    tty_printer_tx #(.CLKS_PER_BIT(C), .STOP_BITS(S), .FORCE_B7(1'b1)) u_dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .EN(EN), .IR(IR), .AC(AC),
        .ck1(ck1), .ck2(ck2), .ck3(ck3), .stb1(stb1), .stb2(stb2),
        .done(done1), .pc_ck(pc1), .irq(irq1), .flag(flag1), .busy(busy1), .TXD(txd1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Line level at offset k into a frame whose character is ch.
    function automatic logic exp_txd(input logic [7:0] ch, input bit fb7, input int k);
        int idx;
        if (k < C) return 1'b0;
        if (k < 9 * C) begin
            idx = (k - C) / C;
            if (idx == 7 && fb7) return 1'b1;
            return ch[idx];
        end
        return 1'b1;
    endfunction

    // Model: a frame is a start time plus a character; the buffer is a pending slot.
    int cyc = 0;
    int m_t0 = 0;
    bit m_act = 1'b0, m_pend = 1'b0, m_flag = 1'b0;
    logic [7:0] m_ch = 8'h00, m_pch = 8'h00;
    bit ld_s, cl_s, end_s, was_idle;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cyc = 0; m_t0 = 0; m_act = 1'b0; m_pend = 1'b0; m_flag = 1'b0;
        end else begin
            ld_s  = EN & stb2 & IR[2];
            cl_s  = EN & stb2 & IR[1];
            end_s = m_act && (cyc - m_t0 == FL - 1);
            was_idle = !m_act;
            if (end_s) begin
                m_act = 1'b0; m_flag = 1'b1;
            end else if (cl_s) begin
                m_flag = 1'b0;
            end
            if (was_idle && m_pend) begin
                m_act = 1'b1; m_t0 = cyc + 1; m_ch = m_pch; m_pend = 1'b0;
            end
            if (ld_s) begin
                m_pend = 1'b1; m_pch = AC;
            end
            cyc++;
        end
    end

    int ck_k;
    logic e_t0, e_t1, e_pc, e_done, e_busy;

    always @(negedge CLK) begin
        if (chk_en) begin
            ck_k   = cyc - m_t0;
            e_t0   = m_act ? exp_txd(m_ch, 1'b0, ck_k) : 1'b1;
            e_t1   = m_act ? exp_txd(m_ch, 1'b1, ck_k) : 1'b1;
            e_done = EN & ck3;
            e_pc   = EN & stb1 & IR[0] & m_flag;
            e_busy = m_act | m_pend;
            chk("txd0", txd0, e_t0);     chk("txd1", txd1, e_t1);
            chk("flag0", flag0, m_flag); chk("flag1", flag1, m_flag);
            chk("irq0", irq0, m_flag);   chk("irq1", irq1, m_flag);
            chk("busy0", busy0, e_busy); chk("busy1", busy1, e_busy);
            chk("done0", done0, e_done); chk("done1", done1, e_done);
            chk("pc0", pc0, e_pc);       chk("pc1", pc1, e_pc);
        end
    end

    task automatic next_cyc();
        @(posedge CLK);
        #2;
    endtask

    // One IOT: stb1 cycle, stb2 cycle (AC valid), ck3 cycle, then bus released.
    task automatic iot(input bit en, input logic [2:0] fn, input logic [7:0] ac);
        @(posedge CLK); #1;
        EN = en; IR = fn; ck1 = 1'b1; stb1 = 1'b1;
        #2 pc_a = pc0;
        @(posedge CLK); #1;
        ck1 = 1'b0; stb1 = 1'b0; ck2 = 1'b1; stb2 = 1'b1; AC = ac;
        @(posedge CLK); #1;
        ck2 = 1'b0; stb2 = 1'b0; ck3 = 1'b1;
        #2 done_c = done0;
        @(posedge CLK); #1;
        EN = 1'b0; IR = 3'b000; ck3 = 1'b0;
    endtask

    task automatic wait_flag_rise(input string nm);
        int n;
        n = 0;
        while (flag0 !== 1'b1 && n < 200) begin
            next_cyc();
            n++;
        end
        chk(nm, {31'd0, flag0}, 32'd1);
    endtask

    // Sample dut0 TXD mid-bit for start, 8 data and 2 stop periods.
    task automatic capture_frame(input int skip, output logic [10:0] v);
        repeat (skip) next_cyc();
        for (int j = 0; j < 11; j++) begin
            v[j] = txd0;
            if (j < 10) repeat (C) next_cyc();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] fr;
        logic [10:0] exp_fr;

        repeat (3) @(posedge CLK);
        #2;
        chk("rst_txd", txd0, 32'd1);
        chk("rst_flag", flag0, 32'd0);
        chk("rst_busy", busy0, 32'd0);
        chk_en = 1'b1;
        #1 RESET_N = 1'b1;

        // 6046 with 'A': full frame shape and flag timing.
        iot(1'b1, 3'b110, 8'h41);
        capture_frame(1, fr);
        exp_fr = {2'b11, 8'h41, 1'b0};
        chk("frame_41", fr, exp_fr);
        repeat (2) next_cyc();
        chk("flag_last_stop", flag0, 32'd0);
        chk("txd_last_stop", txd0, 32'd1);
        next_cyc();
        chk("flag_after_stop", flag0, 32'd1);
        chk("irq_after_stop", irq0, 32'd1);

        // 6041 skips on a set flag without clearing it; 6042 clears.
        iot(1'b1, 3'b001, 8'h00);
        chk("skip_pc", pc_a, 32'd1);
        chk("skip_done", done_c, 32'd1);
        chk("skip_flag_kept", flag0, 32'd1);
        iot(1'b1, 3'b010, 8'h00);
        chk("clr_no_pc", pc_a, 32'd0);
        chk("clr_flag", flag0, 32'd0);

        // Back-to-back characters: second START two cycles after first STOP.
        iot(1'b1, 3'b110, 8'h55);
        repeat (10) @(posedge CLK);
        iot(1'b1, 3'b100, 8'hAA);
        chk("busy_mid", busy0, 32'd1);
        wait_flag_rise("flag_55");
        chk("gap_idle", txd0, 32'd1);
        next_cyc();
        chk("aa_start", txd0, 32'd0);
        iot(1'b1, 3'b010, 8'h00);
        chk("clr_mid_aa", flag0, 32'd0);
        wait_flag_rise("flag_aa");

        // Two loads during a frame: only the last survives.
        iot(1'b1, 3'b110, 8'h0F);
        repeat (5) @(posedge CLK);
        iot(1'b1, 3'b100, 8'h11);
        iot(1'b1, 3'b100, 8'h22);
        wait_flag_rise("flag_0f");
        capture_frame(2, fr);
        exp_fr = {2'b11, 8'h22, 1'b0};
        chk("frame_22", fr, exp_fr);
        repeat (5) next_cyc();

        // EN low: nothing happens even with all IR bits and strobes.
        iot(1'b0, 3'b111, 8'hFF);
        chk("en0_pc", pc_a, 32'd0);
        chk("en0_done", done_c, 32'd0);
        chk("en0_flag", flag0, 32'd1);
        chk("en0_busy", busy0, 32'd0);

        // Frame end coincident with 6042: set wins.
        iot(1'b1, 3'b110, 8'h3C);
        repeat (41) @(posedge CLK);
        iot(1'b1, 3'b010, 8'h00);
        chk("set_beats_clr", flag0, 32'd1);

        // Forced bit 7 on 0x00, then reset inside the data phase.
        iot(1'b1, 3'b100, 8'h00);
        repeat (33) next_cyc();
        chk("b7_plain", txd0, 32'd0);
        chk("b7_forced", txd1, 32'd1);
        #1 RESET_N = 1'b0;
        #1;
        chk("rst_mid_txd0", txd0, 32'd1);
        chk("rst_mid_txd1", txd1, 32'd1);
        chk("rst_mid_flag", flag0, 32'd0);
        chk("rst_mid_busy", busy1, 32'd0);
        repeat (2) @(posedge CLK);
        #3 RESET_N = 1'b1;
        repeat (60) next_cyc();
        chk("post_rst_busy", busy0, 32'd0);
        chk("post_rst_txd", txd1, 32'd1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tty_printer_tx.md
Name: tty_printer_tx

Overview:
- Device end of the 604x teleprinter IOT group.
- Responds to TSF, TCF, TPC and TLS issued by the CPU sequencer.
- Holds one character in a buffer, serialises it onto an asynchronous TXD line, and maintains the printer flag that drives skip and interrupt request.
- Sits beside the keyboard-receive logic; its done, pc_ck and irq outputs are ORed into the CPU's done_, pc_ck_ and irqRq nets.

Parameters:
- CLKS_PER_BIT, 434, CLK cycles per serial bit (must be >= 2).
- STOP_BITS, 2, number of stop bits per frame (1 or 2).
- FORCE_B7, 0, when 1 the transmitted data bit 7 is forced to 1 (ASR-33 mark parity).

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- EN  in  1  instruction is IOT 604x (decoded upstream).
- IR  in  3  IR[2:0] IOT function bits.
- AC  in  8  low 8 bits of AC (PDP AC4..AC11).
- ck1  in  1  sequencer step-1 window.
- ck2  in  1  sequencer step-2 window.
- ck3  in  1  sequencer step-3 window.
- stb1  in  1  single-cycle commit pulse inside ck1.
- stb2  in  1  single-cycle commit pulse inside ck2.
- done  out  1  instruction complete.
- pc_ck  out  1  skip request (PC increment pulse).
- irq  out  1  interrupt request.
- flag  out  1  printer flag (visible for the front panel).
- busy  out  1  shifter active or buffer full.
- TXD  out  1  serial output, idle high.

Behaviour:
- Reset (async, RESET_N=0):
  - flag=0, TXD=1, busy=0.
  - Buffer empty, shifter in IDLE, all counters 0.
  - Reset mid-frame aborts the frame immediately; TXD returns to 1.
- IOT decode, all gated by EN:
  - pc_ck = EN & stb1 & IR[0] & flag (combinational). Sampled before any clear, so 6043 skips and then clears.
  - On EN & stb2 & IR[1]: flag cleared.
  - On EN & stb2 & IR[2]: AC latched into the buffer, buffer marked full.
  - done = EN & ck3 (combinational).
  - 6046 therefore clears the flag and loads in the same cycle.
  - When EN=0, done and pc_ck are 0 regardless of the ck/stb inputs.
- Buffer:
  - A single entry.
  - A load while the buffer is already full overwrites the pending character; there is no error indication.
- Shifter FSM (states in package: IDLE, START, DATA, STOP):
  - IDLE: TXD=1. If the buffer is full, move the buffer into the shift register, mark the buffer empty, go to START on the next cycle.
  - START: TXD=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each for CLKS_PER_BIT cycles. Bit index 0..7; exit after index 7. Bit 7 = 1 if FORCE_B7.
  - STOP: TXD=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
  - Leaving STOP sets flag=1. If a clear (stb2 & IR[1]) occurs in the same cycle, the set wins.
  - A character loaded during a frame starts in the cycle after the return to IDLE, so START begins 2 cycles after STOP ends.
- Latency: load at stb2 in cycle N; buffer valid at N+1; TXD falls at N+2 when the shifter was IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. Counter and bit index reset to 0 on every state entry.
- busy = (state != IDLE) | buffer full.
- irq = flag (no separate enable in this group).

Decomposition:
- Shared package tty_pkg:
  - State enum tty_tx_state_t.
  - IOT bit constants IOT_SKIP=0, IOT_CLRF=1, IOT_LOAD=2.
  - Device code constants TTY_KBD=6'o03, TTY_PRN=6'o04.
  - Function returning the counter width for CLKS_PER_BIT.
- One sub-module, tty_bit_timer: the baud counter, with restart input and bit_end output. It is reused by the keyboard receiver.

Test Plan:
- Reset, then 6046 with AC=8'h41, CLKS_PER_BIT=4, STOP_BITS=2 -> TXD: 0 for 4 cycles, bits 1,0,0,0,0,0,1,0 for 4 cycles each, 1 for 8 cycles; flag rises the cycle after STOP ends; irq=1.
- flag=1, issue 6041 -> pc_ck pulses exactly in the stb1 cycle, done during ck3, flag remains 1. Then issue 6042 -> no pc_ck, flag=0 after stb2.
- 6046 AC=8'h55, then 6044 AC=8'hAA mid-frame -> busy held, 0x55 frame completes, 0xAA START begins 2 cycles after the first STOP ends, flag set after each frame.
- Two loads (8'h11 then 8'h22) during an active frame -> only 0x22 follows; 0x11 never appears on TXD.
- FORCE_B7=1, load 8'h00 -> data bits 0,0,0,0,0,0,0,1. RESET_N low during DATA -> TXD=1 and flag=0 immediately, no frame resumes after release.
- EN=0 with ck/stb activity and IR=3'b111 -> no done, no pc_ck, no load. Then STOP end coincident with 6042 -> flag ends at 1.
